bus_write_regbank: RTL and testbench

Destination register bank on the processor's 16-bit internal bus: the write-side counterpart of the bus read multiplexer. Captures bus data into one of fourteen architectural registers (N, M, P, R1, ROW, COL, CURR, SUM, STA, STB, STC, A, B, R), selected by a 4-bit write-select code. Optionally applies in-place increments for loop counters. Sits between the bus and the datapath/control unit, which consume the register outputs directly.

---
 rtl/bus_write_regbank.sv | 111 +++++++++++
 tb/tb_bus_write_regbank.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/bus_write_regbank.sv
// Write-side register bank on the 16-bit internal bus: fourteen architectural registers loaded by select code.
// Optional in-place increment path enabled by defining REG_INC_EN.
module bus_write_regbank #(
   parameter int DATA_W   = 16,
   parameter int NARROW_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [3:0]          WTB_sel,
   input  logic                WTB_en,
   input  logic [DATA_W-1:0]   datain,
   input  logic [3:0]          INC_sel,
   input  logic                INC_en,
   output logic [NARROW_W-1:0] reg_N,
   output logic [NARROW_W-1:0] reg_M,
   output logic [NARROW_W-1:0] reg_P,
   output logic [NARROW_W-1:0] reg_ROW,
   output logic [NARROW_W-1:0] reg_COL,
   output logic [NARROW_W-1:0] reg_CURR,
   output logic [DATA_W-1:0]   reg_R1,
   output logic [DATA_W-1:0]   reg_SUM,
   output logic [DATA_W-1:0]   reg_STA,
   output logic [DATA_W-1:0]   reg_STB,
   output logic [DATA_W-1:0]   reg_STC,
   output logic [DATA_W-1:0]   reg_A,
   output logic [DATA_W-1:0]   reg_B,
   output logic [DATA_W-1:0]   reg_R,
   output logic                wr_ack,
   output logic                inc_wrap
);

   localparam int NN = 6;
   localparam int NW = 8;
   // Select codes owned by each storage slot; narrow and wide banks kept apart so no bit goes unused.
   localparam logic [3:0] N_CODE [NN] = '{4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7};
   localparam logic [3:0] W_CODE [NW] = '{4'd4, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14};

   logic [NARROW_W-1:0] nar_q [NN];
   logic [NARROW_W-1:0] nar_d [NN];
   logic [DATA_W-1:0]   wid_q [NW];
   logic [DATA_W-1:0]   wid_d [NW];
   logic                wr_ack_q, wr_ack_d;
   logic                inc_wrap_q, inc_wrap_d;
   logic                wr_ok, inc_ok;

   assign wr_ok = WTB_en && (WTB_sel != 4'd0) && (WTB_sel != 4'd15);

`ifdef REG_INC_EN
   assign inc_ok = INC_en && (INC_sel != 4'd0) && (INC_sel != 4'd15);
`else
   logic unused_inc;
   assign unused_inc = ^{INC_sel, INC_en};
   assign inc_ok     = 1'b0;
`endif

   // A write to the same register shadows the increment, so the wrap flag stays low then.
   always_comb begin
      wr_ack_d   = wr_ok;
      inc_wrap_d = 1'b0;
      for (int i = 0; i < NN; i++) begin
         nar_d[i] = nar_q[i];
         if (wr_ok && (WTB_sel == N_CODE[i])) begin
            nar_d[i] = datain[NARROW_W-1:0];
         end else if (inc_ok && (INC_sel == N_CODE[i])) begin
            nar_d[i]   = nar_q[i] + NARROW_W'(1);
            inc_wrap_d = &nar_q[i];
         end
      end
      for (int i = 0; i < NW; i++) begin
         wid_d[i] = wid_q[i];
         if (wr_ok && (WTB_sel == W_CODE[i])) begin
            wid_d[i] = datain;
         end else if (inc_ok && (INC_sel == W_CODE[i])) begin
            wid_d[i]   = wid_q[i] + DATA_W'(1);
            inc_wrap_d = &wid_q[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NN; i++) nar_q[i] <= '0;
         for (int i = 0; i < NW; i++) wid_q[i] <= '0;
         wr_ack_q   <= 1'b0;
         inc_wrap_q <= 1'b0;
      end else begin
         for (int i = 0; i < NN; i++) nar_q[i] <= nar_d[i];
         for (int i = 0; i < NW; i++) wid_q[i] <= wid_d[i];
         wr_ack_q   <= wr_ack_d;
         inc_wrap_q <= inc_wrap_d;
      end
   end

   assign reg_N    = nar_q[0];
   assign reg_M    = nar_q[1];
   assign reg_P    = nar_q[2];
   assign reg_ROW  = nar_q[3];
   assign reg_COL  = nar_q[4];
   assign reg_CURR = nar_q[5];
   assign reg_R1   = wid_q[0];
   assign reg_SUM  = wid_q[1];
   assign reg_STA  = wid_q[2];
   assign reg_STB  = wid_q[3];
   assign reg_STC  = wid_q[4];
   assign reg_A    = wid_q[5];
   assign reg_B    = wid_q[6];
   assign reg_R    = wid_q[7];
   assign wr_ack   = wr_ack_q;
   assign inc_wrap = inc_wrap_q;

endmodule

// File: tb/tb_bus_write_regbank.sv
// Bench for bus_write_regbank: directed test-plan cases plus random traffic against an array model.
// Expectations follow REG_INC_EN the same way the design does.
module tb_bus_write_regbank;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  WTB_sel, INC_sel;
   logic        WTB_en, INC_en;
   logic [15:0] datain;
   logic [7:0]  reg_N, reg_M, reg_P, reg_ROW, reg_COL, reg_CURR;
   logic [15:0] reg_R1, reg_SUM, reg_STA, reg_STB, reg_STC, reg_A, reg_B, reg_R;
   logic        wr_ack, inc_wrap;

`ifdef REG_INC_EN
   localparam bit INC_ON = 1'b1;
`else
   localparam bit INC_ON = 1'b0;
`endif

   bus_write_regbank dut (
      .clk(clk), .rst(rst), .WTB_sel(WTB_sel), .WTB_en(WTB_en), .datain(datain),
      .INC_sel(INC_sel), .INC_en(INC_en),
      .reg_N(reg_N), .reg_M(reg_M), .reg_P(reg_P), .reg_ROW(reg_ROW), .reg_COL(reg_COL),
      .reg_CURR(reg_CURR), .reg_R1(reg_R1), .reg_SUM(reg_SUM), .reg_STA(reg_STA),
      .reg_STB(reg_STB), .reg_STC(reg_STC), .reg_A(reg_A), .reg_B(reg_B), .reg_R(reg_R),
      .wr_ack(wr_ack), .inc_wrap(inc_wrap)
   );

   always #5 clk = ~clk;

   int unsigned m [1:14];
   bit          exp_ack, exp_wrap;
   int          n_cmp = 0;
   int          n_bad = 0;

   function automatic int unsigned reg_mod(input int code);
      return (code inside {1, 2, 3, 5, 6, 7}) ? 256 : 65536;
   endfunction

   function automatic logic [31:0] dut_reg(input int code);
      case (code)
         1: return {24'd0, reg_N};     2: return {24'd0, reg_M};
         3: return {24'd0, reg_P};     4: return {16'd0, reg_R1};
         5: return {24'd0, reg_ROW};   6: return {24'd0, reg_COL};
         7: return {24'd0, reg_CURR};  8: return {16'd0, reg_SUM};
         9: return {16'd0, reg_STA};   10: return {16'd0, reg_STB};
         11: return {16'd0, reg_STC};  12: return {16'd0, reg_A};
         13: return {16'd0, reg_B};    default: return {16'd0, reg_R};
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_update(input bit r, input int ws, input bit we, input int unsigned d,
                               input int is, input bit ie);
      bit wv, iv;
      if (r) begin
         for (int i = 1; i <= 14; i++) m[i] = 0;
         exp_ack  = 0;
         exp_wrap = 0;
         return;
      end
      wv = we && ws >= 1 && ws <= 14;
      iv = INC_ON && ie && is >= 1 && is <= 14 && !(wv && ws == is);
      exp_ack  = wv;
      exp_wrap = 0;
      if (iv) begin
         exp_wrap = (m[is] == reg_mod(is) - 1);
         m[is]    = (m[is] + 1) % reg_mod(is);
      end
      if (wv) m[ws] = d % reg_mod(ws);
   endtask

   task automatic step(input bit r, input logic [3:0] ws, input bit we, input logic [15:0] d,
                       input logic [3:0] is, input bit ie);
      rst = r; WTB_sel = ws; WTB_en = we; datain = d; INC_sel = is; INC_en = ie;
      @(posedge clk);
      model_update(r, int'(ws), we, int'(d), int'(is), ie);
      #1;
      for (int i = 1; i <= 14; i++) chk($sformatf("reg%0d", i), dut_reg(i), m[i]);
      chk("wr_ack", wr_ack, exp_ack);
      chk("inc_wrap", inc_wrap, exp_wrap);
   endtask

   initial begin
      for (int i = 1; i <= 14; i++) m[i] = 32'hDEAD;
      exp_ack = 0; exp_wrap = 0;
      rst = 1; WTB_sel = 0; WTB_en = 0; datain = 0; INC_sel = 0; INC_en = 0;

      step(1, 0, 0, 16'h0, 0, 0);
      step(1, 0, 0, 16'h0, 0, 0);
      step(0, 0, 0, 16'h0, 0, 0);

      // narrow truncation on ROW
      step(0, 5, 1, 16'hABCD, 0, 0);
      chk("row_trunc", reg_ROW, 8'hCD);
      step(0, 0, 0, 16'h0, 0, 0);
      chk("ack_drop", wr_ack, 1'b0);

      // invalid selects
      step(0, 0, 1, 16'hFFFF, 0, 0);
      step(0, 15, 1, 16'hFFFF, 0, 0);

      // CURR wrap
      step(0, 7, 1, 16'h00FE, 0, 0);
      step(0, 0, 0, 16'h0, 7, 1);
      step(0, 0, 0, 16'h0, 7, 1);
      chk("curr_after_2inc", reg_CURR, INC_ON ? 8'h00 : 8'hFE);
      chk("curr_wrap_flag", inc_wrap, INC_ON);
      step(0, 0, 0, 16'h0, 0, 0);

      // collisions
      step(0, 8, 1, 16'h0010, 8, 1);
      chk("sum_collide", reg_SUM, 16'h0010);
      step(0, 12, 1, 16'h1234, 8, 1);
      chk("a_parallel", reg_A, 16'h1234);
      chk("sum_parallel", reg_SUM, INC_ON ? 16'h0011 : 16'h0010);

      // wide wrap, and same-register collision at all-ones must not flag a wrap
      step(0, 13, 1, 16'hFFFF, 0, 0);
      step(0, 13, 1, 16'h0042, 13, 1);
      step(0, 0, 0, 16'h0, 13, 1);
      step(0, 9, 1, 16'hFFFF, 0, 0);
      step(0, 0, 0, 16'h0, 9, 1);

      // reset wins over a presented write
      step(0, 14, 1, 16'h7777, 0, 0);
      step(1, 14, 1, 16'h5555, 14, 1);
      chk("r_reset", reg_R, 16'h0);
      chk("ack_reset", wr_ack, 1'b0);

      // random traffic; small data pool makes all-ones values and wraps frequent
      for (int n = 0; n < 600; n++) begin
         logic [15:0] d;
         case ($urandom_range(0, 3))
            0: d = 16'hFFFF;
            1: d = 16'h00FF;
            2: d = 16'hFFFE;
            default: d = 16'($urandom);
         endcase
         step(($urandom_range(0, 40) == 0), 4'($urandom_range(0, 15)), 1'($urandom),
              d, 4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
